song_sequencer: RTL and testbench

- Parametrised note sequencer that plays a programmable song from an internal note RAM into the piano key/voice path.
- Drives the same key_on/key/duration interface that the tone generator already consumes.
- Each entry carries a key, a length in beat units and a rest flag.
- Adds start/stop/pause control, a runtime song length, optional looping, an inter-note articulation gap and a completion pulse.

---
 rtl/song_sequencer.sv | 135 +++++++++++++
 tb/tb_song_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Note sequencer: plays {rest, dur, key} entries from a small note RAM as
// key_on/key/duration gates, with start/stop/pause, looping and a done pulse.
module song_sequencer #(
  parameter int KEY_W       = 4,
  parameter int DUR_W       = 4,
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 5,
  parameter int UNIT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wr_en,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [DUR_W+KEY_W:0]   i_wr_data,
  input  logic [ADDR_W:0]        i_song_len,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_pause,
  input  logic                   i_loop,
  output logic                   o_key_on,
  output logic [KEY_W-1:0]       o_key,
  output logic [6:0]             o_duration,
  output logic                   o_playing,
  output logic [ADDR_W-1:0]      o_note_idx,
  output logic                   o_done
);

  localparam int CNT_W = $clog2((2**DUR_W) * UNIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] UNIT_LEN = CNT_W'(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LEN  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_NOTE, S_GAP, S_END} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [DUR_W+KEY_W:0]  r_mem [DEPTH];
  logic [CNT_W-1:0]      r_cnt;
  logic [ADDR_W-1:0]     r_idx;
  logic [KEY_W-1:0]      r_key;
  logic [DUR_W-1:0]      r_dur;
  logic                  r_rest;
  logic                  r_zeroDone;

  logic [DUR_W+KEY_W:0]  w_entry;
  logic [DUR_W-1:0]      w_effDur;
  logic [CNT_W-1:0]      w_noteLoad;
  logic                  w_lastNote;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // A zero-length field plays as one beat unit; the gap is carved out of the note.
  assign w_entry    = r_mem[r_idx];
  assign w_effDur   = (w_entry[KEY_W +: DUR_W] == '0) ? DUR_W'(1) : w_entry[KEY_W +: DUR_W];
  assign w_noteLoad = CNT_W'(w_effDur) * UNIT_LEN - GAP_LEN - CNT_ONE;
  assign w_lastNote = ({1'b0, r_idx} + (ADDR_W+1)'(1)) >= i_song_len;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (i_stop) begin
      w_nextState = S_IDLE;
    end else if (!(i_pause && r_state != S_IDLE)) begin
      case (r_state)
        S_IDLE:  if (i_start && i_song_len != '0) w_nextState = S_FETCH;
        S_FETCH: w_nextState = S_NOTE;
        S_NOTE:  if (r_cnt == '0) w_nextState = S_GAP;
        S_GAP:   if (r_cnt == '0) w_nextState = (w_lastNote && !i_loop) ? S_END : S_FETCH;
        S_END:   w_nextState = S_IDLE;
        default: w_nextState = S_IDLE;
      endcase
    end
  end

  // Datapath follows the same stop > pause > normal priority as the state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_key      <= '0;
      r_dur      <= '0;
      r_rest     <= 1'b0;
      r_zeroDone <= 1'b0;
    end else begin
      r_zeroDone <= 1'b0;
      if (i_stop) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_state == S_IDLE) begin
        if (i_start) begin
          r_idx <= '0;
          if (i_song_len == '0) r_zeroDone <= 1'b1;
        end
      end else if (!i_pause) begin
        case (r_state)
          S_FETCH: begin
            r_key  <= w_entry[KEY_W-1:0];
            r_dur  <= w_effDur;
            r_rest <= w_entry[DUR_W+KEY_W];
            r_cnt  <= w_noteLoad;
          end
          S_NOTE: begin
            if (r_cnt == '0) r_cnt <= GAP_LOAD;
            else             r_cnt <= r_cnt - CNT_ONE;
          end
          S_GAP: begin
            if (r_cnt != '0)      r_cnt <= r_cnt - CNT_ONE;
            else if (!w_lastNote) r_idx <= r_idx + ADDR_W'(1);
            else if (i_loop)      r_idx <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_key_on  = (r_state == S_NOTE) && !r_rest && !i_pause;
    o_playing = (r_state != S_IDLE);
    o_done    = ((r_state == S_END) && !i_pause) || r_zeroDone;
  end

  assign o_key      = r_key;
  assign o_duration = 7'(r_dur);
  assign o_note_idx = r_idx;

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: table-driven single notes, hand-written corner
// sequences, and random songs with random pause checked against a timeline model.
module tb_song_sequencer;

  localparam int KW = 4;
  localparam int DW = 4;
  localparam int DP = 8;
  localparam int AW = 3;
  localparam int UC = 10;
  localparam int GC = 2;

  logic          clk;
  logic          rstN;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [DW+KW:0] wrData;
  logic [AW:0]   songLen;
  logic          start, stop, pause, loopEn;
  logic          keyOn;
  logic [KW-1:0] key;
  logic [6:0]    duration;
  logic          playing;
  logic [AW-1:0] noteIdx;
  logic          done;

  int errors = 0;
  int checks = 0;

  bit mRest [DP];
  int mDur  [DP];
  int mKey  [DP];

  typedef struct { bit on; bit play; bit done; bit chkKey; int key; int idx; } exp_t;
  exp_t trace[$];

  typedef struct { bit rest; int dur; int key; int expOn; int expDone; int expDur; } vec_t;
  vec_t vecs[5];

  song_sequencer #(
    .KEY_W(KW), .DUR_W(DW), .DEPTH(DP), .ADDR_W(AW), .UNIT_CYCLES(UC), .GAP_CYCLES(GC)
  ) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_wr_en(wrEn), .i_wr_addr(wrAddr), .i_wr_data(wrData),
    .i_song_len(songLen), .i_start(start), .i_stop(stop), .i_pause(pause), .i_loop(loopEn),
    .o_key_on(keyOn), .o_key(key), .o_duration(duration), .o_playing(playing),
    .o_note_idx(noteIdx), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit pz);
    start = st;
    stop  = sp;
    pause = pz;
  endtask

  task automatic writeEntry(input int a, input bit r, input int d, input int k);
    wrEn   = 1'b1;
    wrAddr = AW'(a);
    wrData = {r, DW'(d), KW'(k)};
    mRest[a] = r;
    mDur[a]  = d;
    mKey[a]  = k;
    advance();
    wrEn = 1'b0;
  endtask

  // Expected unpaused timeline from the start cycle: fetch, sounding part, gap per note, then done.
  function automatic void buildTrace(input int len);
    exp_t e;
    int d;
    trace.delete();
    e = '{on:0, play:0, done:0, chkKey:0, key:0, idx:0};
    trace.push_back(e);
    for (int i = 0; i < len; i++) begin
      d = (mDur[i] == 0) ? 1 : mDur[i];
      e = '{on:0, play:1, done:0, chkKey:0, key:0, idx:i};
      trace.push_back(e);
      for (int c = 0; c < d * UC - GC; c++) begin
        e = '{on:!mRest[i], play:1, done:0, chkKey:1, key:mKey[i], idx:i};
        trace.push_back(e);
      end
      for (int c = 0; c < GC; c++) begin
        e = '{on:0, play:1, done:0, chkKey:1, key:mKey[i], idx:i};
        trace.push_back(e);
      end
    end
    e = '{on:0, play:1, done:1, chkKey:0, key:0, idx:len-1};
    trace.push_back(e);
    e = '{on:0, play:0, done:0, chkKey:0, key:0, idx:0};
    trace.push_back(e);
  endfunction

  task automatic runModel(input int len, input bit randPause);
    int p = 0;
    int cyc = 0;
    bit pz;
    exp_t e;
    buildTrace(len);
    songLen = (AW+1)'(len);
    loopEn  = 1'b0;
    while (p < trace.size() && cyc < 3000) begin
      pz = randPause && (cyc > 0) && ($urandom_range(0, 4) == 0);
      applyStimulus(cyc == 0, 1'b0, pz);
      @(negedge clk);
      e = trace[p];
      if (pz && e.play) begin
        checkOutput("paused key_on", 32'(keyOn), 32'(0));
        checkOutput("paused playing", 32'(playing), 32'(1));
        checkOutput("paused done", 32'(done), 32'(0));
        checkOutput("paused note_idx", 32'(noteIdx), 32'(e.idx));
      end else begin
        checkOutput("model key_on", 32'(keyOn), 32'(e.on));
        checkOutput("model playing", 32'(playing), 32'(e.play));
        checkOutput("model done", 32'(done), 32'(e.done));
        if (e.play) checkOutput("model note_idx", 32'(noteIdx), 32'(e.idx));
        if (e.chkKey) checkOutput("model key", 32'(key), 32'(e.key));
        p++;
      end
      advance();
      cyc++;
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    if (p < trace.size()) checkOutput("model timeout", 32'(p), 32'(trace.size()));
  endtask

  initial begin
    int bad, doneCyc, doneCnt, onCnt, playSeen, len;
    bit expOn, pz;

    vecs[0] = '{rest:0, dur:1, key:5,  expOn:8,  expDone:12, expDur:1};
    vecs[1] = '{rest:0, dur:0, key:3,  expOn:8,  expDone:12, expDur:1};
    vecs[2] = '{rest:1, dur:2, key:3,  expOn:0,  expDone:22, expDur:2};
    vecs[3] = '{rest:0, dur:3, key:15, expOn:28, expDone:32, expDur:3};
    vecs[4] = '{rest:0, dur:7, key:9,  expOn:68, expDone:72, expDur:7};

    rstN = 1'b0; wrEn = 1'b0; wrAddr = '0; wrData = '0; songLen = '0; loopEn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset key_on", 32'(keyOn), 32'(0));
    checkOutput("reset key", 32'(key), 32'(0));
    checkOutput("reset duration", 32'(duration), 32'(0));
    checkOutput("reset playing", 32'(playing), 32'(0));
    checkOutput("reset note_idx", 32'(noteIdx), 32'(0));
    checkOutput("reset done", 32'(done), 32'(0));
    advance();
    rstN = 1'b1;
    advance();

    // Single-note table
    for (int v = 0; v < 5; v++) begin
      writeEntry(0, vecs[v].rest, vecs[v].dur, vecs[v].key);
      songLen = 4'd1;
      onCnt = 0; doneCnt = 0; doneCyc = -1;
      for (int cyc = 0; cyc < 100; cyc++) begin
        applyStimulus(cyc == 0, 1'b0, 1'b0);
        @(negedge clk);
        if (keyOn === 1'b1) onCnt++;
        if (done === 1'b1) begin
          doneCnt++;
          if (doneCyc < 0) doneCyc = cyc;
        end
        advance();
      end
      checkOutput("table key_on cycles", 32'(onCnt), 32'(vecs[v].expOn));
      checkOutput("table done cycle", 32'(doneCyc), 32'(vecs[v].expDone));
      checkOutput("table done count", 32'(doneCnt), 32'(1));
      checkOutput("table duration", 32'(duration), 32'(vecs[v].expDur));
      checkOutput("table key", 32'(key), 32'(vecs[v].key));
    end

    // Three-note song, exact cycle map
    writeEntry(0, 1'b0, 1, 0);
    writeEntry(1, 1'b0, 2, 4);
    writeEntry(2, 1'b0, 1, 5);
    songLen = 4'd3; loopEn = 1'b0; bad = 0; doneCyc = -1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      @(negedge clk);
      expOn = (cyc >= 2 && cyc <= 9) || (cyc >= 13 && cyc <= 30) || (cyc >= 34 && cyc <= 41);
      if (keyOn !== expOn) bad++;
      if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
      if (cyc == 5)  checkOutput("song duration n0", 32'(duration), 32'(1));
      if (cyc == 20) checkOutput("song duration n1", 32'(duration), 32'(2));
      if (cyc == 20) checkOutput("song key n1", 32'(key), 32'(4));
      if (cyc == 36) checkOutput("song key n2", 32'(key), 32'(5));
      if (cyc == 44) checkOutput("song playing at done", 32'(playing), 32'(1));
      if (cyc == 45) checkOutput("song playing after", 32'(playing), 32'(0));
      advance();
    end
    checkOutput("song key_on pattern errors", 32'(bad), 32'(0));
    checkOutput("song done cycle", 32'(doneCyc), 32'(44));

    // Same song looping
    loopEn = 1'b1; doneCnt = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
      if (cyc == 44) checkOutput("loop gap key_on", 32'(keyOn), 32'(0));
      if (cyc == 45) begin
        checkOutput("loop restart key_on", 32'(keyOn), 32'(1));
        checkOutput("loop restart key", 32'(key), 32'(0));
        checkOutput("loop restart idx", 32'(noteIdx), 32'(0));
      end
      advance();
    end
    checkOutput("loop done count", 32'(doneCnt), 32'(0));
    applyStimulus(1'b0, 1'b1, 1'b0);
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0);
    loopEn = 1'b0;
    advance();

    // Pause inside a dur=1 note after four sounding cycles
    writeEntry(0, 1'b0, 1, 6);
    songLen = 4'd1; bad = 0; doneCyc = -1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      pz = (cyc >= 6 && cyc <= 10);
      applyStimulus(cyc == 0, 1'b0, pz);
      @(negedge clk);
      expOn = (cyc >= 2 && cyc <= 5) || (cyc >= 11 && cyc <= 14);
      if (keyOn !== expOn) bad++;
      if (done === 1'b1 && doneCyc < 0) doneCyc = cyc;
      advance();
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("pause key_on pattern errors", 32'(bad), 32'(0));
    checkOutput("pause done cycle", 32'(doneCyc), 32'(17));

    // Stop together with start and pause mid second note
    writeEntry(0, 1'b0, 1, 1);
    writeEntry(1, 1'b0, 1, 2);
    songLen = 4'd2;
    for (int cyc = 0; cyc < 15; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      advance();
    end
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("stop pre idx", 32'(noteIdx), 32'(1));
    advance();
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stop playing", 32'(playing), 32'(0));
    checkOutput("stop key_on", 32'(keyOn), 32'(0));
    checkOutput("stop note_idx", 32'(noteIdx), 32'(0));
    doneCnt = 0; playSeen = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      advance();
      @(negedge clk);
      if (done === 1'b1) doneCnt++;
      if (playing === 1'b1) playSeen++;
    end
    checkOutput("stop done count", 32'(doneCnt), 32'(0));
    checkOutput("stop stays idle", 32'(playSeen), 32'(0));
    advance();

    // Asynchronous reset during the gap of the second note
    writeEntry(1, 1'b0, 1, 9);
    for (int cyc = 0; cyc < 21; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      advance();
    end
    checkOutput("pre-reset idx", 32'(noteIdx), 32'(1));
    checkOutput("pre-reset key", 32'(key), 32'(9));
    rstN = 1'b0;
    #2;
    checkOutput("async reset key", 32'(key), 32'(0));
    checkOutput("async reset duration", 32'(duration), 32'(0));
    checkOutput("async reset playing", 32'(playing), 32'(0));
    checkOutput("async reset note_idx", 32'(noteIdx), 32'(0));
    checkOutput("async reset key_on", 32'(keyOn), 32'(0));
    advance();
    rstN = 1'b1;
    advance();

    // Start with an empty song
    songLen = 4'd0; doneCnt = 0; doneCyc = -1; playSeen = 0;
    for (int cyc = 0; cyc < 7; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      @(negedge clk);
      if (done === 1'b1) begin
        doneCnt++;
        if (doneCyc < 0) doneCyc = cyc;
      end
      if (playing === 1'b1) playSeen++;
      advance();
    end
    checkOutput("empty done count", 32'(doneCnt), 32'(1));
    checkOutput("empty done cycle", 32'(doneCyc), 32'(1));
    checkOutput("empty playing", 32'(playSeen), 32'(0));

    // Rewrite entry 2 while note 0 plays
    writeEntry(0, 1'b0, 1, 1);
    writeEntry(1, 1'b0, 1, 2);
    writeEntry(2, 1'b0, 1, 3);
    songLen = 4'd3;
    for (int cyc = 0; cyc < 46; cyc++) begin
      applyStimulus(cyc == 0, 1'b0, 1'b0);
      wrEn = (cyc == 5);
      wrAddr = 3'd2;
      wrData = {1'b0, 4'd1, 4'd12};
      @(negedge clk);
      if (cyc == 25) begin
        checkOutput("rewrite key", 32'(key), 32'(12));
        checkOutput("rewrite idx", 32'(noteIdx), 32'(2));
        checkOutput("rewrite key_on", 32'(keyOn), 32'(1));
      end
      advance();
    end
    wrEn = 1'b0;
    mKey[2] = 12;

    // Model-checked songs: the rewritten song, then random songs with random pause
    runModel(3, 1'b0);
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, DP);
      for (int a = 0; a < DP; a++)
        writeEntry(a, ($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 15));
      runModel(len, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
